// File: rtl/divrem_pkg.sv
// Shared opcode encodings and pipeline-depth helper for the divide/remainder unit.
package divrem_pkg;

   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;

   // Counted by repeated addition so the block never needs a divide operator.
   function automatic int divrem_nstages(int width, int radix_bits, int dps);
      int n;
      n = 0;
      for (int acc = radix_bits * dps; acc <= width; acc += radix_bits * dps)
         n++;
      return n;
   endfunction

endpackage

// File: rtl/divrem_digit.sv
// One combinational restoring radix-2^RADIX_BITS digit step.
module divrem_digit
   import divrem_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int RADIX_BITS = 4
) (
   input  logic [WIDTH-1:0]                                      rem_in,
   input  logic [WIDTH-1:0]                                      quo_in,
   input  logic [(1<<RADIX_BITS)-2:0][WIDTH+RADIX_BITS-1:0]      mult,
   output logic [WIDTH-1:0]                                      rem_out,
   output logic [WIDTH-1:0]                                      quo_out
);

   localparam int NMULT = (1 << RADIX_BITS) - 1;

   logic [WIDTH+RADIX_BITS-1:0] trial;
   logic [RADIX_BITS-1:0]       digit;
   logic [WIDTH-1:0]            sub;

   // The true difference is below the divisor, so only the low WIDTH bits matter.
   always_comb begin
      trial = {rem_in, quo_in[WIDTH-1 -: RADIX_BITS]};
      digit = '0;
      sub   = '0;
      for (int k = 1; k <= NMULT; k++) begin
         if (trial >= mult[k-1]) begin
            digit = RADIX_BITS'(k);
            sub   = mult[k-1][WIDTH-1:0];
         end
      end
      rem_out = trial[WIDTH-1:0] - sub;
      quo_out = {quo_in[WIDTH-RADIX_BITS-1:0], digit};
   end

endmodule

// File: rtl/divrem_pipe.sv
// Fully pipelined signed/unsigned divide and remainder unit with tag pass-through
// and output backpressure: prep register, NSTAGES iteration registers, output register.
module divrem_pipe
   import divrem_pkg::*;
#(
   parameter int WIDTH            = 32,
   parameter int RADIX_BITS       = 4,
   parameter int DIGITS_PER_STAGE = 2,
   parameter int TAG_W            = 5
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             order,
   output logic             accepted,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs1,
   input  logic [WIDTH-1:0] rs2,
   input  logic [TAG_W-1:0] tag_in,
   output logic             done,
   input  logic             out_ready,
   output logic [WIDTH-1:0] rd,
   output logic [TAG_W-1:0] tag_out
);

   localparam int NSTAGES = divrem_nstages(WIDTH, RADIX_BITS, DIGITS_PER_STAGE);
   localparam int NMULT   = (1 << RADIX_BITS) - 1;
   localparam int MW      = WIDTH + RADIX_BITS;

   typedef logic [NMULT-1:0][MW-1:0] mult_t;

   if (NSTAGES * RADIX_BITS * DIGITS_PER_STAGE != WIDTH) begin : g_bad_width
      $error("divrem_pipe: WIDTH must be a multiple of RADIX_BITS*DIGITS_PER_STAGE");
   end

   logic advance;
   assign advance  = ~done | out_ready;
   assign accepted = order & advance & rstn;

   logic             is_signed;
   logic [WIDTH-1:0] a_abs;
   logic [WIDTH-1:0] b_abs;
   mult_t            mult_prep;

   // Multiples built as 2k = k<<1 and 2k+1 = 2k + 1x.
   always_comb begin
      is_signed = (op == OP_DIV) || (op == OP_REM);
      a_abs     = (is_signed && rs1[WIDTH-1]) ? -rs1 : rs1;
      b_abs     = (is_signed && rs2[WIDTH-1]) ? -rs2 : rs2;
      mult_prep = '0;
      mult_prep[0] = MW'(b_abs);
      for (int k = 2; k <= NMULT; k++) begin
         if (k[0] == 1'b0)
            mult_prep[k-1] = mult_prep[(k >> 1) - 1] << 1;
         else
            mult_prep[k-1] = mult_prep[k-2] + mult_prep[0];
      end
   end

   logic             v_q    [0:NSTAGES];
   logic [TAG_W-1:0] tag_q  [0:NSTAGES];
   logic             rsel_q [0:NSTAGES];
   logic             qneg_q [0:NSTAGES];
   logic             rneg_q [0:NSTAGES];
   logic             dz_q   [0:NSTAGES];
   logic [WIDTH-1:0] orig_q [0:NSTAGES];
   logic [WIDTH-1:0] quo_q  [0:NSTAGES];
   logic [WIDTH-1:0] rem_q  [0:NSTAGES];
   mult_t            mult_q [0:NSTAGES-1];

   logic [WIDTH-1:0] quo_nx [1:NSTAGES];
   logic [WIDTH-1:0] rem_nx [1:NSTAGES];

   for (genvar s = 1; s <= NSTAGES; s++) begin : g_stage
      logic [WIDTH-1:0] quo_c [0:DIGITS_PER_STAGE];
      logic [WIDTH-1:0] rem_c [0:DIGITS_PER_STAGE];
      assign quo_c[0] = quo_q[s-1];
      assign rem_c[0] = rem_q[s-1];
      for (genvar d = 0; d < DIGITS_PER_STAGE; d++) begin : g_digit
         divrem_digit #(
            .WIDTH      (WIDTH),
            .RADIX_BITS (RADIX_BITS)
         ) u_digit (
            .rem_in  (rem_c[d]),
            .quo_in  (quo_c[d]),
            .mult    (mult_q[s-1]),
            .rem_out (rem_c[d+1]),
            .quo_out (quo_c[d+1])
         );
      end
      assign quo_nx[s] = quo_c[DIGITS_PER_STAGE];
      assign rem_nx[s] = rem_c[DIGITS_PER_STAGE];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int s = 0; s <= NSTAGES; s++) begin
            v_q[s]    <= 1'b0;
            tag_q[s]  <= '0;
            rsel_q[s] <= 1'b0;
            qneg_q[s] <= 1'b0;
            rneg_q[s] <= 1'b0;
            dz_q[s]   <= 1'b0;
            orig_q[s] <= '0;
            quo_q[s]  <= '0;
            rem_q[s]  <= '0;
         end
         for (int s = 0; s < NSTAGES; s++)
            mult_q[s] <= '0;
      end else if (advance) begin
         v_q[0]    <= accepted;
         tag_q[0]  <= tag_in;
         rsel_q[0] <= op[1];
         qneg_q[0] <= is_signed & (rs1[WIDTH-1] ^ rs2[WIDTH-1]);
         rneg_q[0] <= is_signed & rs1[WIDTH-1];
         dz_q[0]   <= (rs2 == '0);
         orig_q[0] <= rs1;
         quo_q[0]  <= a_abs;
         rem_q[0]  <= '0;
         mult_q[0] <= mult_prep;
         for (int s = 1; s <= NSTAGES; s++) begin
            v_q[s]    <= v_q[s-1];
            tag_q[s]  <= tag_q[s-1];
            rsel_q[s] <= rsel_q[s-1];
            qneg_q[s] <= qneg_q[s-1];
            rneg_q[s] <= rneg_q[s-1];
            dz_q[s]   <= dz_q[s-1];
            orig_q[s] <= orig_q[s-1];
            quo_q[s]  <= quo_nx[s];
            rem_q[s]  <= rem_nx[s];
         end
         for (int s = 1; s < NSTAGES; s++)
            mult_q[s] <= mult_q[s-1];
      end
   end

   logic [WIDTH-1:0] q_fin;
   logic [WIDTH-1:0] r_fin;
   logic [WIDTH-1:0] result;

   // Divide-by-zero overrides sign fix-up for signed and unsigned ops alike.
   always_comb begin
      q_fin = qneg_q[NSTAGES] ? -quo_q[NSTAGES] : quo_q[NSTAGES];
      r_fin = rneg_q[NSTAGES] ? -rem_q[NSTAGES] : rem_q[NSTAGES];
      if (dz_q[NSTAGES]) begin
         q_fin = '1;
         r_fin = orig_q[NSTAGES];
      end
      result = rsel_q[NSTAGES] ? r_fin : q_fin;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         done    <= 1'b0;
         rd      <= '0;
         tag_out <= '0;
      end else if (advance) begin
         done    <= v_q[NSTAGES];
         rd      <= result;
         tag_out <= tag_q[NSTAGES];
      end
   end

endmodule
